// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands on start and adds LSB-first, one bit per clock.
// Optional subtract mode (sub port, A-B in two's complement) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  // One full adder cell: two half-adder stages with the carries ORed.
  logic ha1_s, ha1_c, ha2_c, bit_s, carry_next;
  always_comb begin
    ha1_s      = a_sr_q[0] ^ b_sr_q[0];
    ha1_c      = a_sr_q[0] & b_sr_q[0];
    bit_s      = ha1_s ^ carry_q;
    ha2_c      = ha1_s & carry_q;
    carry_next = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
`ifdef SERIAL_ADD_SUB_EN
          b_sr_d  = sub ? ~b_in : b_in;
          carry_d = sub;
`else
          b_sr_d  = b_in;
          carry_d = 1'b0;
`endif
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = carry_next;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = carry_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl (WIDTH=8 and WIDTH=2 instances) against an arithmetic model.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sub_r;
  logic [7:0] a_in, b_in, sum;
  logic       busy, done, cout;

  logic       s2_start, s2_sub;
  logic [1:0] s2_a, s2_b, s2_sum;
  logic       s2_busy, s2_done, s2_cout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_r),
`endif
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(s2_sub),
`endif
    .a_in(s2_a), .b_in(s2_b), .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                     input logic keep, input logic [7:0] ra, input logic [7:0] rb);
    int unsigned exact;
    if (sb) exact = ((int'(a) - int'(b)) & 32'hFF) | ((a >= b) ? 32'h100 : 32'h0);
    else    exact = int'(a) + int'(b);
    a_in = a; b_in = b; sub_r = sb; start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
    chk("sum_cleared_on_accept", {24'h0, sum}, 32'h0);
    chk("cout_cleared_on_accept", {31'h0, cout}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      a_in = ra; b_in = rb;
      chk("busy_in_run", {31'h0, busy}, 32'h1);
      chk("done_in_run", {31'h0, done}, 32'h0);
      @(negedge clk);
    end
    chk("done_pulse", {31'h0, done}, 32'h1);
    chk("busy_at_done", {31'h0, busy}, 32'h0);
    chk("sum", {24'h0, sum}, exact & 32'hFF);
    chk("cout", {31'h0, cout}, (exact >> 8) & 32'h1);
    @(negedge clk);
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    chk("sum_hold", {24'h0, sum}, exact & 32'hFF);
    chk("cout_hold", {31'h0, cout}, (exact >> 8) & 32'h1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int unsigned e2;
    rst = 1'b1; start = 1'b0; sub_r = 1'b0; a_in = '0; b_in = '0;
    s2_start = 1'b0; s2_sub = 1'b0; s2_a = '0; s2_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_sum", {24'h0, sum}, 32'h0);
    chk("rst_cout", {31'h0, cout}, 32'h0);
    chk("rst_w2_sum", {30'h0, s2_sum}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h35, 8'h4A, 1'b0, 1'b0, 8'hC3, 8'h5C);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    op8(8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF);

    // start held high throughout; operands changed during RUN/DONE are picked up only at the next IDLE accept
    op8(8'h0F, 8'h01, 1'b0, 1'b1, 8'hAA, 8'h11);
    op8(8'hAA, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);

    // reset in the 4th RUN cycle aborts with no done pulse
    a_in = 8'h80; b_in = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_sum", {24'h0, sum}, 32'h0);
    chk("abort_cout", {31'h0, cout}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {30'h0, busy, done}, 32'h0);
    end
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h7F, 8'h7F);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(8'($urandom), 8'($urandom), 1'b0, 1'b0, ra, rb);
    end
    op8(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);

`ifdef SERIAL_ADD_SUB_EN
    op8(8'h10, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00);
    op8(8'h01, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) op8(8'($urandom), 8'($urandom), 1'b1, 1'b0, 8'h00, 8'h00);
`endif

    // WIDTH=2: exhaustive operand pairs
    for (int i = 0; i < 16; i++) begin
      s2_a = 2'(i >> 2); s2_b = 2'(i); s2_start = 1'b1;
      e2 = int'(s2_a) + int'(s2_b);
      @(negedge clk);
      s2_start = 1'b0; s2_a = ~s2_a; s2_b = ~s2_b;
      for (int c = 0; c < 2; c++) begin
        chk("w2_busy", {30'h0, s2_busy, s2_done}, 32'h2);
        @(negedge clk);
      end
      chk("w2_done", {30'h0, s2_busy, s2_done}, 32'h1);
      chk("w2_sum", {30'h0, s2_sum}, e2 & 32'h3);
      chk("w2_cout", {31'h0, s2_cout}, (e2 >> 2) & 32'h1);
      @(negedge clk);
      chk("w2_idle", {30'h0, s2_busy, s2_done}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: accepts two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock.
- Datapath per bit is one full adder built from two half-adder stages plus an OR on the carries; this block owns the operand shift registers, carry flop, bit counter and result register.
- Trades area for latency in small datapaths: one 1-bit adder cell is reused WIDTH times.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on accepted start
- b_in  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result; holds until next accepted start
- cout  output  1  carry out of MSB; holds with sum

Interface:
- One clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset, sampled at a clk edge with rst=1, forces the following; rst overrides all other inputs on that edge:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and counter cleared.
- State IDLE:
  - start=1 captures a_in into A_sr and b_in into B_sr.
  - Clears carry to 0, counter to 0, sum to 0, cout to 0, then goes to RUN.
  - start=0 stays in IDLE; outputs hold.
- State RUN, each cycle:
  - Bit operation: s = A_sr[0]^B_sr[0]^carry; carry_next = (A_sr[0]&B_sr[0]) | (carry&(A_sr[0]^B_sr[0])).
  - A_sr and B_sr shift right by 1.
  - sum shifts right by 1 with s inserted at bit WIDTH-1.
  - counter increments.
  - When counter==WIDTH-1 in the current cycle, cout<=carry_next and the next state is DONE.
  - start is ignored; no re-capture and no error.
- State DONE:
  - done=1 for exactly this cycle; busy=0; next state is IDLE unconditionally.
  - start is ignored in DONE, so back-to-back operations need start in the IDLE cycle after done.
- Latency:
  - start accepted at edge k gives busy=1 in cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles.
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum; cout is bit WIDTH of the exact sum.
  - Counter width is clog2(WIDTH); no wrap occurs before DONE.
- Operands are captured: changing a_in/b_in after the accept edge has no effect on the result.
- sum/cout read during RUN hold partial data; consumers qualify them with done or with IDLE after done.
- Reset mid-RUN aborts the operation, no done pulse, and all outputs go to 0 on that edge.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands on an accepted start.
  - sub=1: B_sr loads ~b_in and carry initialises to 1, giving A-B in two's complement.
  - cout=1 means no borrow (A>=B unsigned); sub=0 behaves exactly as without the macro.
- Undefined: no sub port; addition only; carry always initialises to 0.

Test Plan:
- WIDTH=8, a_in=8'h35, b_in=8'h4A, start one cycle -> busy high 8 cycles, done on cycle 9 after accept edge, sum=8'h7F, cout=0.
- a_in=8'hFF, b_in=8'h01 -> sum=8'h00, cout=1 at done; then a_in=8'h00, b_in=8'h00 -> sum=8'h00, cout=0 (carry cleared between ops).
- Start held high continuously with a_in=8'h0F, b_in=8'h01 -> first result sum=8'h10; operands changed to 8'hAA/8'h11 during RUN and DONE ignored; next accept in IDLE after done yields sum=8'hBB, cout=0.
- rst=1 on the 4th RUN cycle of 8'h80+8'h80 -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE; no done pulse follows; fresh 8'h80+8'h80 gives sum=8'h00, cout=1.
- WIDTH=2 instance, a_in=2'b11, b_in=2'b11 -> busy 2 cycles, done on cycle 3, sum=2'b10, cout=1.
- SERIAL_ADD_SUB_EN defined:
  - sub=1, 8'h10-8'h01 -> sum=8'h0F, cout=1.
  - sub=1, 8'h01-8'h02 -> sum=8'hFF, cout=0.
